fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//   Instruction-fetch stage. Owns the PC and drives the instruction-memory/I-cache request.
//   Produces the PC+2 / instruction pair and the flush request consumed by the IF/ID pipeline
//   register. Absorbs variable-latency cache misses, stalls, decode-stage redirects and HLT.
// PARAMETERS
//   ADDR_W      16       PC / memory address width
//   INSTR_W     16       instruction width
//   RESET_PC    16'h0000 PC value loaded on reset
//   HLT_OPCODE  4'hF     value of instr[15:12] that halts fetch
// PORTS
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous reset, active-low
//   stall_en     in   1        hazard stall; hold PC, IF/ID not written this cycle
//   redirect_en  in   1        taken branch resolved in decode
//   redirect_pc  in   ADDR_W   branch target, valid with redirect_en
//   imem_req     out  1        fetch request to I-mem/I-cache
//   imem_addr    out  ADDR_W   fetch address (= PC)
//   imem_ready   in   1        imem_rdata valid this cycle (miss -> low for N cycles)
//   imem_rdata   in   INSTR_W  fetched instruction
//   pc_add_out   out  ADDR_W   PC+2 of the presented instruction
//   instr_out    out  INSTR_W  instruction to IF/ID; 16'h0000 when fetch_flush=1
//   fetch_flush  out  1        IF/ID must load a bubble this cycle
//   halted       out  1        HLT fetched; fetch stopped
// BEHAVIOUR
//   Reset (async, rst_n=0): PC=RESET_PC, state=RUN, redir_pend=0, redir_tgt=0;
//     imem_req=0 while rst_n=0; pc_add_out=RESET_PC+2, instr_out=0, fetch_flush=1, halted=0.
//   States: RUN, HALT. imem_addr=PC always; pc_add_out=PC+2 (mod 2^16, 0xFFFE wraps to 0x0000).
//   Redirect capture: redirect_en=1 in any state loads redir_tgt<=redirect_pc, redir_pend<=1;
//     the newest redirect wins. eff_redir = redirect_en | redir_pend; eff_tgt = redirect_en ?
//     redirect_pc : redir_tgt.
//   RUN: imem_req=1. Priority per cycle:
//     1. stall_en=1: PC holds, fetch_flush=0 (flush overrides IF/ID write-enable, so no flush
//        during a stall), imem_ready ignored; redirect still captured per above.
//     2. eff_redir: PC<=eff_tgt, redir_pend<=0, fetch_flush=1 (wrong-path word dropped,
//        whether or not imem_ready).
//     3. imem_ready=0 (miss): PC holds, fetch_flush=1.
//     4. imem_ready=1, rdata[15:12]==HLT_OPCODE: present instr, fetch_flush=0, PC holds,
//        next state HALT.
//     5. imem_ready=1 otherwise: present instr, fetch_flush=0, PC<=PC+2.
//   HALT: imem_req=0, halted=1, fetch_flush=1, PC frozen. eff_redir=1 (branch older than HLT
//     taken) -> PC<=eff_tgt, redir_pend<=0, halted=0, state RUN. HALT is left only by a
//     redirect or by reset.
//   Latency: a cache hit presents the instruction in the same cycle as the request. Each miss
//     cycle inserts exactly one bubble. A redirect costs one bubble.
//   Reset mid-miss: request drops asynchronously; any pending redirect is discarded.
// STRUCTURE
//   Shared defines include: HLT_OPCODE, RESET_PC, NOP encoding (16'h0000).
//   PC and redir_tgt use the existing dff_16bit register cell; state and redir_pend use dff.
//   Next-PC selection stays in a single sub-module, pc_next_mux.
//   No other sub-modules.
// TESTING
//   1. Reset, then always-ready memory returning ADD words: PC steps 0,2,4,6;
//      pc_add_out 2,4,6,8; fetch_flush=0 from the first post-reset cycle.
//   2. imem_ready=0 for 3 cycles at PC=0x0010: 3 cycles of fetch_flush=1 with PC=0x0010
//      held; then instr presented, PC->0x0012.
//   3. stall_en=1 for 2 cycles at PC=0x0020 with imem_ready=1: PC holds, fetch_flush=0;
//      PC->0x0022 after stall drops.
//   4. redirect_en with redirect_pc=0x0100 during the cycle-2 miss and a later ready: one
//      bubble, next imem_addr=0x0100, wrong-path word never presented.
//   5. redirect_en with redirect_pc=0x0040 while stall_en=1: PC holds through the stall;
//      first unstalled cycle gives fetch_flush=1 and PC<=0x0040.
//   6. Fetch 16'hF000 at PC=0x0030: presented once, then halted=1, imem_req=0, PC=0x0030.
//      Later redirect to 0x0050 resumes fetch. rst_n pulse mid-miss -> PC=0, imem_req=0.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: default constants,
// the fetch state encoding and the next-PC select encoding.
package fetch_pc_unit_pkg;

  localparam logic [15:0] DEFAULT_RESET_PC   = 16'h0000;
  localparam logic [3:0]  DEFAULT_HLT_OPCODE = 4'hF;
  // Bubble word loaded into IF/ID whenever the fetch stage flushes.
  localparam logic [15:0] NOP_INSTR          = 16'h0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_TGT  = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/dff.sv
// Single-bit register cell with asynchronous active-low reset.
module dff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Capture d on every rising edge; force RST_VAL while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/dff_16bit.sv
// 16-bit register cell with asynchronous active-low reset.
module dff_16bit #(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // Capture d on every rising edge; force RST_VAL while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/pc_next_mux.sv
// Next-PC selection for the fetch stage. Also produces PC+2, which is both
// the sequential successor and the pc_add_out value handed to IF/ID.
module pc_next_mux
  import fetch_pc_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc_q,
  input  logic [ADDR_W-1:0] eff_tgt,
  input  pc_sel_e           pc_sel,
  output logic [ADDR_W-1:0] pc_d,
  output logic [ADDR_W-1:0] pc_plus2
);

  // PC+2 wraps naturally at the address width (0xFFFE -> 0x0000).
  always_comb begin
    pc_plus2 = pc_q + ADDR_W'(2);
  end

  // Pick hold, sequential increment or redirect target.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_HOLD: pc_d = pc_q;
      PC_INC:  pc_d = pc_plus2;
      PC_TGT:  pc_d = eff_tgt;
      default: pc_d = pc_q;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues the I-mem request and hands
// the PC+2 / instruction pair plus a flush strobe to the IF/ID register.
//
// Memory handshake: imem_req is high in RUN (and out of reset) and
// imem_addr always equals the PC. The memory answers in the same cycle by
// raising imem_ready with imem_rdata valid; imem_ready low is a miss and the
// request simply stays up with the same address until a ready cycle. A word
// returned while the stage stalls or redirects is discarded.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter int          INSTR_W    = 16,
  parameter logic [15:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [3:0]  HLT_OPCODE = DEFAULT_HLT_OPCODE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_en,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_add_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               fetch_flush,
  output logic               halted
);

  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] redir_tgt_d, redir_tgt_q;
  logic              redir_pend_d, redir_pend_q;
  logic              state_raw_d, state_raw_q;
  fetch_state_e      state_d, state_q;

  logic              eff_redir;
  logic [ADDR_W-1:0] eff_tgt;
  logic [ADDR_W-1:0] pc_plus2;
  pc_sel_e           pc_sel;
  logic              flush_int;
  logic              is_hlt;

  // State registers built from the shared register cells.
  dff_16bit #(.RST_VAL(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pc_d),
    .q     (pc_q)
  );

  dff_16bit #(.RST_VAL(16'h0000)) u_redir_tgt_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (redir_tgt_d),
    .q     (redir_tgt_q)
  );

  dff #(.RST_VAL(1'b0)) u_redir_pend_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (redir_pend_d),
    .q     (redir_pend_q)
  );

  dff #(.RST_VAL(1'b0)) u_state_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (state_raw_d),
    .q     (state_raw_q)
  );

  // Enum view of the state bit held in the register cell.
  always_comb begin
    state_q     = fetch_state_e'(state_raw_q);
    state_raw_d = logic'(state_d);
  end

  // A redirect seen this cycle takes precedence over a remembered one, so
  // the newest branch target always wins.
  always_comb begin
    eff_redir   = redirect_en | redir_pend_q;
    eff_tgt     = redirect_en ? redirect_pc : redir_tgt_q;
    redir_tgt_d = redirect_en ? redirect_pc : redir_tgt_q;
    is_hlt      = (imem_rdata[INSTR_W-1:INSTR_W-4] == HLT_OPCODE);
  end

  // Per-cycle fetch decision: stall, redirect, miss, halt, then hit.
  always_comb begin
    pc_sel       = PC_HOLD;
    state_d      = state_q;
    flush_int    = 1'b1;
    redir_pend_d = redirect_en ? 1'b1 : redir_pend_q;
    case (state_q)
      ST_RUN: begin
        if (stall_en) begin
          // IF/ID holds; a flush here would clobber the held instruction.
          flush_int = 1'b0;
        end else if (eff_redir) begin
          // Whatever the memory returned is wrong-path and is dropped.
          pc_sel       = PC_TGT;
          redir_pend_d = 1'b0;
          flush_int    = 1'b1;
        end else if (!imem_ready) begin
          flush_int = 1'b1;
        end else if (is_hlt) begin
          // HLT is presented once; the PC parks on it.
          flush_int = 1'b0;
          state_d   = ST_HALT;
        end else begin
          flush_int = 1'b0;
          pc_sel    = PC_INC;
        end
      end
      ST_HALT: begin
        // Only a redirect from an older branch can restart fetch.
        if (eff_redir) begin
          pc_sel       = PC_TGT;
          redir_pend_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  pc_next_mux #(.ADDR_W(ADDR_W)) u_pc_next_mux (
    .pc_q     (pc_q),
    .eff_tgt  (eff_tgt),
    .pc_sel   (pc_sel),
    .pc_d     (pc_d),
    .pc_plus2 (pc_plus2)
  );

  // Outputs; the request drops immediately when reset asserts.
  always_comb begin
    imem_req    = rst_n & (state_q == ST_RUN);
    imem_addr   = pc_q;
    pc_add_out  = pc_plus2;
    fetch_flush = ~rst_n | flush_int;
    instr_out   = fetch_flush ? INSTR_W'(NOP_INSTR) : imem_rdata;
    halted      = (state_q == ST_HALT);
  end

endmodule
